// File: rtl/decode_issue.sv
// decode_issue -- decode/issue front end for the execute stage.
//
// Accepts 16-bit instruction words over a valid/ready handshake, decodes
// them, reads a 4-entry register file and drives an ALU code plus two
// operands into execute.  The execute result is sampled back into the
// destination register WB_LAT edges after the issue edge.  Only one
// instruction is ever in flight, so there are no hazards to resolve.
//
// Instruction word: [15:12] opc, [11:10] ra, [9:8] rb, [7:0] imm
//   0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 INC, 5 DEC, 6..15 illegal
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   instruction word present
//   instr_ready  out  decoder can accept (combinational, high only in IDLE)
//   instr        in   instruction word
//   result_in    in   execute result (LED_out)
//   ALU_out      out  registered execute opcode
//   op1_out      out  registered operand 1
//   op2_out      out  registered operand 2
//   busy         out  high while waiting for the result
//   illegal      out  sticky illegal-opcode flag
//
// Build option: define DECODE_TRAP_EN to make opcodes 6..15 set the sticky
// illegal flag.  Without it they behave as NOP and illegal is tied low.

module decode_issue #(
  parameter int DATA_W = 16,
  parameter int WB_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] result_in,
  output logic [7:0]        ALU_out,
  output logic [DATA_W-1:0] op1_out,
  output logic [DATA_W-1:0] op2_out,
  output logic              busy,
  output logic              illegal
);

  localparam int CNT_W = $clog2(WB_LAT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_dst;
  logic [DATA_W-1:0]  r_regs [4];

  logic               w_accept;
  logic [3:0]         w_opc;
  logic [1:0]         w_ra;
  logic [1:0]         w_rb;
  logic [7:0]         w_imm;

  assign w_opc       = instr[15:12];
  assign w_ra        = instr[11:10];
  assign w_rb        = instr[9:8];
  assign w_imm       = instr[7:0];
  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state == S_WAIT);
  assign w_accept    = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dst   <= '0;
      ALU_out <= 8'h00;
      op1_out <= '0;
      op2_out <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Operands come from the register values before this edge.
            case (w_opc)
              4'd1: r_regs[w_ra] <= DATA_W'(w_imm);
              4'd2, 4'd3, 4'd4, 4'd5: begin
                case (w_opc)
                  4'd2:    ALU_out <= 8'h01;
                  4'd3:    ALU_out <= 8'h03;
                  4'd4:    ALU_out <= 8'h0F;
                  default: ALU_out <= 8'h10;
                endcase
                op1_out <= r_regs[w_ra];
                op2_out <= (w_opc == 4'd2 || w_opc == 4'd3) ? r_regs[w_rb] : '0;
                r_dst   <= w_ra;
                r_cnt   <= CNT_W'(WB_LAT - 1);
                r_state <= S_WAIT;
              end
              default: ;  // NOP and illegal codes issue nothing
            endcase
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            // Execute has registered its result by now; take it unmodified.
            r_regs[r_dst] <= result_in;
            ALU_out       <= 8'h00;
            op1_out       <= '0;
            op2_out       <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DECODE_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_accept && (w_opc >= 4'd6)) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] led_out;
  logic [7:0]        alu_code;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              busy;
  logic              illegal;

  int checks = 0;
  int passes = 0;

`ifdef DECODE_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  decode_issue #(.DATA_W(DATA_W), .WB_LAT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .result_in   (led_out),
    .ALU_out     (alu_code),
    .op1_out     (op1),
    .op2_out     (op2),
    .busy        (busy),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execute stage: one output register, arithmetic modulo 2^DATA_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_out <= '0;
    else begin
      case (alu_code)
        8'h01:   led_out <= op1 + op2;
        8'h03:   led_out <= op1 - op2;
        8'h0F:   led_out <= op1 + 1'b1;
        8'h10:   led_out <= op1 - 1'b1;
        default: led_out <= '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present one word for a single accept edge, then drop valid at edge+1.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu", alu_code, 8'h00);
    chk("rst_op1", op1, 16'h0000);
    chk("rst_op2", op2, 16'h0000);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // LDI R1,5 ; LDI R2,3 ; ADD R1,R2
    send(16'h1405);
    chk("ldi_ready", instr_ready, 1'b1);
    chk("ldi_alu", alu_code, 8'h00);
    send(16'h1803);
    send(16'h2600);
    chk("add_alu", alu_code, 8'h01);
    chk("add_op1", op1, 16'h0005);
    chk("add_op2", op2, 16'h0003);
    chk("add_busy", busy, 1'b1);
    chk("add_ready", instr_ready, 1'b0);
    step();
    chk("add_e1_busy", busy, 1'b1);
    step();
    chk("add_e2_ready", instr_ready, 1'b1);
    chk("add_e2_alu", alu_code, 8'h00);
    chk("add_e2_op1", op1, 16'h0000);

    // SUB R2,R1 -> R2 = 3 - 8 = 0xFFFB
    send(16'h3900);
    chk("sub_alu", alu_code, 8'h03);
    chk("sub_op1", op1, 16'h0003);
    chk("sub_op2", op2, 16'h0008);
    step(); step();

    // DEC R3 (0 -> 0xFFFF) ; INC R3 (0xFFFF -> 0)
    send(16'h5C00);
    chk("dec_alu", alu_code, 8'h10);
    chk("dec_op1", op1, 16'h0000);
    chk("dec_op2", op2, 16'h0000);
    step(); step();
    send(16'h4C00);
    chk("inc_alu", alu_code, 8'h0F);
    chk("inc_op1", op1, 16'hFFFF);
    step(); step();
    // ADD R3,R2 observes R3 after wrap and R2 after SUB
    send(16'h2E00);
    chk("r3_wrap", op1, 16'h0000);
    chk("r2_sub", op2, 16'hFFFB);
    step(); step();

    // Back-to-back ADD R0,R0 with valid held: R0 doubles 1,2,4 -> 8
    send(16'h1001);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 16'h2000;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b2b_ready_%0d", k), instr_ready, (k % 3) == 0);
      @(posedge clk);
      #1;
      if ((k % 3) == 0) chk($sformatf("b2b_op1_%0d", k), op1, 32'(1 << (k / 3)));
      @(negedge clk);
    end
    instr_valid = 1'b0;

    // ADD R0,R0 then reset one cycle after issue: no write-back
    send(16'h2000);
    chk("pre_rst_op1", op1, 16'h0008);
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_alu", alu_code, 8'h00);
    chk("arst_op1", op1, 16'h0000);
    chk("arst_op2", op2, 16'h0000);
    chk("arst_ready", instr_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    send(16'h2000);
    chk("arst_r0", op1, 16'h0000);
    step(); step();

    // Illegal opcode 7: no issue; flag depends on build
    send(16'h7000);
    chk("ill_ready", instr_ready, 1'b1);
    chk("ill_busy", busy, 1'b0);
    chk("ill_alu", alu_code, 8'h00);
    chk("ill_flag", illegal, ILL_EXP);
    send(16'h0000);
    chk("nop_ready", instr_ready, 1'b1);
    chk("ill_sticky", illegal, ILL_EXP);
    send(16'h1A55);
    chk("ill_sticky2", illegal, ILL_EXP);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ill_rst", illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
